// File: rtl/mpi_pkt_pkg.sv
// Shared definitions for collective packets: opcodes, packet type codes,
// packet and newcomm field positions, and the packet assembly function.
package mpi_pkt_pkg;

  localparam int PKT_W = 84;

  localparam logic [3:0] OP_SHORT_REDUCE     = 4'b1100;
  localparam logic [3:0] OP_LARGE_REDUCE     = 4'b1101;
  localparam logic [3:0] OP_SHORT_ALLREDUCE  = 4'b1110;
  localparam logic [3:0] OP_LARGE_ALLREDUCE  = 4'b1111;

  localparam logic [2:0] PT_REDUCE_ME = 3'b101;
  localparam logic [2:0] PT_X         = 3'b001;
  localparam logic [2:0] PT_Y         = 3'b011;

  localparam int PKT_TYPE_LSB = 81;
  localparam int PKT_DST_LSB  = 72;
  localparam int PKT_SRC_LSB  = 63;
  localparam int PKT_RANK_LSB = 54;
  localparam int PKT_CTX_LSB  = 46;
  localparam int PKT_SEQ_LSB  = 38;
  localparam int PKT_OP_LSB   = 32;
  localparam int PKT_PL_LSB   = 0;

  localparam int NC_VALID    = 49;
  localparam int NC_CTX_LSB  = 41;
  localparam int NC_RANK_LSB = 23;

  function automatic logic [PKT_W-1:0] build_pkt(
    input logic [2:0]  ptype,
    input logic [8:0]  dst,
    input logic [8:0]  src,
    input logic [8:0]  rank,
    input logic [7:0]  ctx,
    input logic [7:0]  seq,
    input logic [3:0]  opcode,
    input logic [31:0] payload
  );
    logic [PKT_W-1:0] p;
    p = '0;
    p[PKT_TYPE_LSB +: 3] = ptype;
    p[PKT_DST_LSB  +: 9] = dst;
    p[PKT_SRC_LSB  +: 9] = src;
    p[PKT_RANK_LSB +: 9] = rank;
    p[PKT_CTX_LSB  +: 8] = ctx;
    p[PKT_SEQ_LSB  +: 8] = seq;
    p[PKT_OP_LSB   +: 4] = opcode;
    p[PKT_PL_LSB   +: 32] = payload;
    return p;
  endfunction

  function automatic logic is_reduce(input logic [3:0] op);
    return (op == OP_SHORT_REDUCE) || (op == OP_LARGE_REDUCE);
  endfunction

  function automatic logic is_allreduce(input logic [3:0] op);
    return (op == OP_SHORT_ALLREDUCE) || (op == OP_LARGE_ALLREDUCE);
  endfunction

endpackage

// File: rtl/pkt_builder.sv
// Combinational assembly of one 84-bit collective packet from its fields.
module pkt_builder
  import mpi_pkt_pkg::*;
(
  input  logic [2:0]       ptype_i,
  input  logic [8:0]       dst_i,
  input  logic [8:0]       src_i,
  input  logic [8:0]       rank_i,
  input  logic [7:0]       ctx_i,
  input  logic [7:0]       seq_i,
  input  logic [3:0]       opcode_i,
  input  logic [31:0]      payload_i,
  output logic [PKT_W-1:0] pkt_o
);
  assign pkt_o = build_pkt(ptype_i, dst_i, src_i, rank_i, ctx_i, seq_i, opcode_i, payload_i);
endmodule

// File: rtl/collective_injector.sv
// Node-side injection sequencer: accepts one host collective command at a time
// and drives reduce_me plus x/y inject packets for exactly one cycle.
module collective_injector
  import mpi_pkt_pkg::*;
#(
  parameter logic [8:0]  NODE_ADDR    = 9'd0,
  parameter logic [8:0]  X_NEIGH_ADDR = 9'd1,
  parameter logic [8:0]  Y_NEIGH_ADDR = 9'd8,
  parameter bit          X_USE_POS    = 1'b1,
  parameter bit          Y_USE_POS    = 1'b1,
  parameter int unsigned GAP_CYCLES   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [49:0]       newcomm,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_opcode,
  input  logic [31:0]       cmd_payload,
  output logic [PKT_W-1:0]  reduce_me,
  output logic [PKT_W-1:0]  xpos_inject,
  output logic [PKT_W-1:0]  xneg_inject,
  output logic [PKT_W-1:0]  ypos_inject,
  output logic [PKT_W-1:0]  yneg_inject,
  output logic              cmd_err,
  output logic              busy,
  output logic [7:0]        seq
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EMIT = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  localparam logic [3:0] GAP_LAST = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [7:0]  seq_q, seq_d;
  logic [3:0]  gap_q, gap_d;
  logic [7:0]  ctx_q, ctx_d;
  logic [8:0]  rank_q, rank_d;
  logic        comm_ok_q, comm_ok_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] payload_q, payload_d;
  logic        all_q, all_d;
  logic        err_q, err_d;

  logic        accept;
  logic        newcomm_unused;

  assign newcomm_unused = ^{newcomm[NC_RANK_LSB-1:0], newcomm[NC_CTX_LSB-1:NC_RANK_LSB+9]};
  assign accept         = cmd_valid && cmd_ready;

  always_comb begin
    state_d   = state_q;
    seq_d     = seq_q;
    gap_d     = gap_q;
    ctx_d     = ctx_q;
    rank_d    = rank_q;
    comm_ok_d = comm_ok_q;
    op_d      = op_q;
    payload_d = payload_q;
    all_d     = all_q;
    err_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (newcomm[NC_VALID]) begin
          ctx_d     = newcomm[NC_CTX_LSB +: 8];
          rank_d    = newcomm[NC_RANK_LSB +: 9];
          comm_ok_d = 1'b1;
        end
        if (accept) begin
          if (is_reduce(cmd_opcode) || is_allreduce(cmd_opcode)) begin
            state_d   = S_EMIT;
            op_d      = cmd_opcode;
            payload_d = cmd_payload;
            all_d     = is_allreduce(cmd_opcode);
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_EMIT: begin
        seq_d = seq_q + 8'd1;
        if (GAP_CYCLES == 0) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_GAP;
          gap_d   = GAP_LAST;
        end
      end
      S_GAP: begin
        if (gap_q == 4'd0) state_d = S_IDLE;
        else               gap_d   = gap_q - 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      seq_q     <= 8'd0;
      gap_q     <= 4'd0;
      ctx_q     <= 8'd0;
      rank_q    <= 9'd0;
      comm_ok_q <= 1'b0;
      op_q      <= 4'd0;
      payload_q <= 32'd0;
      all_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      seq_q     <= seq_d;
      gap_q     <= gap_d;
      ctx_q     <= ctx_d;
      rank_q    <= rank_d;
      comm_ok_q <= comm_ok_d;
      op_q      <= op_d;
      payload_q <= payload_d;
      all_q     <= all_d;
      err_q     <= err_d;
    end
  end

  logic [PKT_W-1:0] red_pkt, x_pkt, y_pkt, x_live, y_live;
  logic             emit;

  pkt_builder u_red (
    .ptype_i(PT_REDUCE_ME), .dst_i(NODE_ADDR), .src_i(NODE_ADDR), .rank_i(rank_q),
    .ctx_i(ctx_q), .seq_i(seq_q), .opcode_i(op_q), .payload_i(payload_q), .pkt_o(red_pkt)
  );
  pkt_builder u_x (
    .ptype_i(PT_X), .dst_i(X_NEIGH_ADDR), .src_i(NODE_ADDR), .rank_i(rank_q),
    .ctx_i(ctx_q), .seq_i(seq_q), .opcode_i(op_q), .payload_i(payload_q), .pkt_o(x_pkt)
  );
  pkt_builder u_y (
    .ptype_i(PT_Y), .dst_i(Y_NEIGH_ADDR), .src_i(NODE_ADDR), .rank_i(rank_q),
    .ctx_i(ctx_q), .seq_i(seq_q), .opcode_i(op_q), .payload_i(payload_q), .pkt_o(y_pkt)
  );

  // Outputs derive from registered state, so an async reset clears them at once.
  assign emit      = (state_q == S_EMIT);
  assign reduce_me = emit ? red_pkt : '0;
  assign x_live    = (emit && all_q) ? x_pkt : '0;
  assign y_live    = (emit && all_q) ? y_pkt : '0;

  generate
    if (X_USE_POS) begin : g_xpos
      assign xpos_inject = x_live;
      assign xneg_inject = '0;
    end else begin : g_xneg
      assign xpos_inject = '0;
      assign xneg_inject = x_live;
    end
    if (Y_USE_POS) begin : g_ypos
      assign ypos_inject = y_live;
      assign yneg_inject = '0;
    end else begin : g_yneg
      assign ypos_inject = '0;
      assign yneg_inject = y_live;
    end
  endgenerate

  assign cmd_ready = (state_q == S_IDLE) && comm_ok_q;
  assign busy      = (state_q == S_EMIT) || (state_q == S_GAP);
  assign cmd_err   = err_q;
  assign seq       = seq_q;

endmodule

// File: tb/tb_collective_injector.sv
// Directed self-checking bench for collective_injector: default positive-port
// instance (gap 1) and a negative-port instance at node 9 (gap 0).
module tb_collective_injector;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // instance A: defaults
  logic [49:0] newcomm_a = '0;
  logic        cmd_valid_a = 1'b0;
  logic [3:0]  cmd_opcode_a = '0;
  logic [31:0] cmd_payload_a = '0;
  logic        cmd_ready_a, cmd_err_a, busy_a;
  logic [7:0]  seq_a;
  logic [83:0] red_a, xpos_a, xneg_a, ypos_a, yneg_a;

  // instance B: node 9, negative ports, no gap
  logic [49:0] newcomm_b = '0;
  logic        cmd_valid_b = 1'b0;
  logic [3:0]  cmd_opcode_b = '0;
  logic [31:0] cmd_payload_b = '0;
  logic        cmd_ready_b, cmd_err_b, busy_b;
  logic [7:0]  seq_b;
  logic [83:0] red_b, xpos_b, xneg_b, ypos_b, yneg_b;

  collective_injector dut_a (
    .clk(clk), .rst(rst), .newcomm(newcomm_a), .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a),
    .cmd_opcode(cmd_opcode_a), .cmd_payload(cmd_payload_a), .reduce_me(red_a),
    .xpos_inject(xpos_a), .xneg_inject(xneg_a), .ypos_inject(ypos_a), .yneg_inject(yneg_a),
    .cmd_err(cmd_err_a), .busy(busy_a), .seq(seq_a)
  );

  collective_injector #(
    .NODE_ADDR(9'd9), .X_NEIGH_ADDR(9'd8), .Y_NEIGH_ADDR(9'd1),
    .X_USE_POS(1'b0), .Y_USE_POS(1'b0), .GAP_CYCLES(0)
  ) dut_b (
    .clk(clk), .rst(rst), .newcomm(newcomm_b), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
    .cmd_opcode(cmd_opcode_b), .cmd_payload(cmd_payload_b), .reduce_me(red_b),
    .xpos_inject(xpos_b), .xneg_inject(xneg_b), .ypos_inject(ypos_b), .yneg_inject(yneg_b),
    .cmd_err(cmd_err_b), .busy(busy_b), .seq(seq_b)
  );

  localparam logic [49:0] NC_A = {1'b1, 8'h00, 9'd0, 9'd0, 2'b10, 3'b010, 9'd1, 9'd2};
  localparam logic [49:0] NC_B = {1'b1, 8'h5A, 9'd0, 9'd3, 2'b00, 3'b010, 9'd0, 9'd0};

  function automatic logic [83:0] pk(input logic [2:0] t, input logic [8:0] dst, input logic [8:0] src,
                                     input logic [8:0] rank, input logic [7:0] ctx, input logic [7:0] sq,
                                     input logic [3:0] op, input logic [31:0] pl);
    return {t, dst, src, rank, ctx, sq, 2'b00, op, pl};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #3;
    checks++; if (red_a !== '0) begin failures++; $display("FAIL reset_reduce_me got=%h exp=0", red_a); end
    checks++; if ({xpos_a, xneg_a, ypos_a, yneg_a} !== '0) begin failures++; $display("FAIL reset_inject got nonzero exp=0"); end
    checks++; if ({cmd_err_a, busy_a, cmd_ready_a} !== 3'b000) begin failures++; $display("FAIL reset_ctrl got=%b exp=000", {cmd_err_a, busy_a, cmd_ready_a}); end
    checks++; if (seq_a !== 8'd0) begin failures++; $display("FAIL reset_seq got=%0d exp=0", seq_a); end
    tick; tick;
    rst = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_no_comm;
    cmd_valid_a = 1'b1; cmd_opcode_a = 4'b1110; cmd_payload_a = 32'd1;
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++; if (cmd_ready_a !== 1'b0) begin failures++; $display("FAIL nocomm_ready cyc=%0d got=%b exp=0", i, cmd_ready_a); end
      checks++; if (red_a !== '0 || busy_a !== 1'b0) begin failures++; $display("FAIL nocomm_out cyc=%0d busy=%b exp busy=0 out=0", i, busy_a); end
    end
    newcomm_a = NC_A; cmd_valid_a = 1'b0;
    #1;
    checks++; if (cmd_ready_a !== 1'b0) begin failures++; $display("FAIL comm_ready_early got=%b exp=0", cmd_ready_a); end
    tick;
    checks++; if (cmd_ready_a !== 1'b1) begin failures++; $display("FAIL comm_ready_rise got=%b exp=1", cmd_ready_a); end
    $display("test_no_comm done");
  endtask

  task automatic test_allreduce;
    logic [83:0] er, ex, ey;
    er = pk(3'b101, 9'd0, 9'd0, 9'd0, 8'h00, 8'd0, 4'b1110, 32'd6);
    ex = pk(3'b001, 9'd1, 9'd0, 9'd0, 8'h00, 8'd0, 4'b1110, 32'd6);
    ey = pk(3'b011, 9'd8, 9'd0, 9'd0, 8'h00, 8'd0, 4'b1110, 32'd6);
    cmd_valid_a = 1'b1; cmd_opcode_a = 4'b1110; cmd_payload_a = 32'd6;
    tick;
    cmd_valid_a = 1'b0;
    checks++; if (red_a !== er) begin failures++; $display("FAIL ar_reduce_me got=%h exp=%h", red_a, er); end
    checks++; if (xpos_a !== ex) begin failures++; $display("FAIL ar_xpos got=%h exp=%h", xpos_a, ex); end
    checks++; if (ypos_a !== ey) begin failures++; $display("FAIL ar_ypos got=%h exp=%h", ypos_a, ey); end
    checks++; if ({xneg_a, yneg_a} !== '0) begin failures++; $display("FAIL ar_neg_ports got nonzero exp=0"); end
    checks++; if (busy_a !== 1'b1 || cmd_ready_a !== 1'b0) begin failures++; $display("FAIL ar_emit_ctrl busy=%b ready=%b exp busy=1 ready=0", busy_a, cmd_ready_a); end
    tick;
    checks++; if ({red_a, xpos_a, ypos_a} !== '0) begin failures++; $display("FAIL ar_after_zero got nonzero exp=0"); end
    checks++; if (seq_a !== 8'd1) begin failures++; $display("FAIL ar_seq got=%0d exp=1", seq_a); end
    checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL ar_gap_busy got=%b exp=1", busy_a); end
    tick;
    checks++; if (busy_a !== 1'b0 || cmd_ready_a !== 1'b1) begin failures++; $display("FAIL ar_idle busy=%b ready=%b exp busy=0 ready=1", busy_a, cmd_ready_a); end
    $display("test_allreduce done");
  endtask

  task automatic test_reduce;
    logic [83:0] er;
    er = pk(3'b101, 9'd0, 9'd0, 9'd0, 8'h00, 8'd1, 4'b1100, 32'hDEADBEEF);
    cmd_valid_a = 1'b1; cmd_opcode_a = 4'b1100; cmd_payload_a = 32'hDEADBEEF;
    tick;
    cmd_valid_a = 1'b0;
    checks++; if (red_a !== er) begin failures++; $display("FAIL red_reduce_me got=%h exp=%h", red_a, er); end
    checks++; if ({xpos_a, xneg_a, ypos_a, yneg_a} !== '0) begin failures++; $display("FAIL red_inject got nonzero exp=0"); end
    tick;
    checks++; if (red_a !== '0 || seq_a !== 8'd2) begin failures++; $display("FAIL red_after seq=%0d exp seq=2 out=0", seq_a); end
    tick;
    $display("test_reduce done");
  endtask

  task automatic test_bad_opcode;
    cmd_valid_a = 1'b1; cmd_opcode_a = 4'b0101; cmd_payload_a = 32'h55;
    tick;
    cmd_valid_a = 1'b0;
    checks++; if (cmd_err_a !== 1'b1) begin failures++; $display("FAIL bad_err got=%b exp=1", cmd_err_a); end
    checks++; if ({red_a, xpos_a, xneg_a, ypos_a, yneg_a} !== '0) begin failures++; $display("FAIL bad_outputs got nonzero exp=0"); end
    checks++; if (busy_a !== 1'b0 || seq_a !== 8'd2) begin failures++; $display("FAIL bad_state busy=%b seq=%0d exp busy=0 seq=2", busy_a, seq_a); end
    tick;
    checks++; if (cmd_err_a !== 1'b0) begin failures++; $display("FAIL bad_err_pulse got=%b exp=0", cmd_err_a); end
    checks++; if (seq_a !== 8'd2) begin failures++; $display("FAIL bad_seq got=%0d exp=2", seq_a); end
    $display("test_bad_opcode done");
  endtask

  task automatic test_comm_hold;
    logic [49:0] nc;
    logic [83:0] e1, e2;
    e1 = pk(3'b101, 9'd0, 9'd0, 9'd0, 8'h00, 8'd2, 4'b1111, 32'h11);
    e2 = pk(3'b101, 9'd0, 9'd0, 9'd0, 8'h00, 8'd3, 4'b1100, 32'h22);
    nc = NC_A;
    nc[48:41] = 8'h77;
    cmd_valid_a = 1'b1; cmd_opcode_a = 4'b1111; cmd_payload_a = 32'h11;
    tick;
    cmd_valid_a = 1'b0; newcomm_a = nc;
    checks++; if (red_a !== e1) begin failures++; $display("FAIL hold_first got=%h exp=%h", red_a, e1); end
    tick;
    nc[49] = 1'b0; newcomm_a = nc;
    tick;
    checks++; if (cmd_ready_a !== 1'b1) begin failures++; $display("FAIL hold_ready got=%b exp=1", cmd_ready_a); end
    cmd_valid_a = 1'b1; cmd_opcode_a = 4'b1100; cmd_payload_a = 32'h22;
    tick;
    cmd_valid_a = 1'b0;
    checks++; if (red_a !== e2) begin failures++; $display("FAIL hold_ctx got=%h exp=%h", red_a, e2); end
    tick; tick;
    newcomm_a = NC_A;
    tick;
    $display("test_comm_hold done");
  endtask

  task automatic test_neg_ports;
    logic [83:0] er, ex, ey, er2;
    er  = pk(3'b101, 9'd9, 9'd9, 9'd3, 8'h5A, 8'd0, 4'b1111, 32'h12345678);
    ex  = pk(3'b001, 9'd8, 9'd9, 9'd3, 8'h5A, 8'd0, 4'b1111, 32'h12345678);
    ey  = pk(3'b011, 9'd1, 9'd9, 9'd3, 8'h5A, 8'd0, 4'b1111, 32'h12345678);
    er2 = pk(3'b101, 9'd9, 9'd9, 9'd3, 8'h5A, 8'd1, 4'b1100, 32'd9);
    newcomm_b = NC_B;
    tick;
    checks++; if (cmd_ready_b !== 1'b1) begin failures++; $display("FAIL neg_ready got=%b exp=1", cmd_ready_b); end
    cmd_valid_b = 1'b1; cmd_opcode_b = 4'b1111; cmd_payload_b = 32'h12345678;
    tick;
    cmd_opcode_b = 4'b1100; cmd_payload_b = 32'd9;
    checks++; if (red_b !== er) begin failures++; $display("FAIL neg_reduce_me got=%h exp=%h", red_b, er); end
    checks++; if (xneg_b !== ex) begin failures++; $display("FAIL neg_xneg got=%h exp=%h", xneg_b, ex); end
    checks++; if (yneg_b !== ey) begin failures++; $display("FAIL neg_yneg got=%h exp=%h", yneg_b, ey); end
    checks++; if ({xpos_b, ypos_b} !== '0) begin failures++; $display("FAIL neg_pos_ports got nonzero exp=0"); end
    tick;
    checks++; if (busy_b !== 1'b0 || cmd_ready_b !== 1'b1 || seq_b !== 8'd1) begin failures++; $display("FAIL nogap_idle busy=%b ready=%b seq=%0d exp 0 1 1", busy_b, cmd_ready_b, seq_b); end
    checks++; if ({red_b, xneg_b, yneg_b} !== '0) begin failures++; $display("FAIL nogap_zero got nonzero exp=0"); end
    tick;
    cmd_valid_b = 1'b0;
    checks++; if (red_b !== er2) begin failures++; $display("FAIL nogap_second got=%h exp=%h", red_b, er2); end
    checks++; if (xneg_b !== '0) begin failures++; $display("FAIL nogap_xneg got=%h exp=0", xneg_b); end
    tick;
    checks++; if (seq_b !== 8'd2) begin failures++; $display("FAIL nogap_seq got=%0d exp=2", seq_b); end
    $display("test_neg_ports done");
  endtask

  task automatic test_back_to_back;
    logic [83:0] er;
    int n;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    newcomm_a = NC_A;
    tick;
    checks++; if (cmd_ready_a !== 1'b1 || seq_a !== 8'd0) begin failures++; $display("FAIL b2b_start ready=%b seq=%0d exp 1 0", cmd_ready_a, seq_a); end
    cmd_valid_a = 1'b1; cmd_opcode_a = 4'b1110; cmd_payload_a = 32'hC0DE;
    for (int c = 0; c < 900; c++) begin
      tick;
      n = c / 3;
      if (c % 3 == 0) begin
        er = pk(3'b101, 9'd0, 9'd0, 9'd0, 8'h00, 8'(n), 4'b1110, 32'hC0DE);
        checks++; if (busy_a !== 1'b1 || red_a !== er) begin failures++; $display("FAIL b2b_emit cmd=%0d busy=%b got=%h exp=%h", n + 1, busy_a, red_a, er); end
      end else if (c % 3 == 1) begin
        checks++; if (busy_a !== 1'b1 || red_a !== '0) begin failures++; $display("FAIL b2b_gap cmd=%0d busy=%b exp busy=1 out=0", n + 1, busy_a); end
      end else begin
        checks++; if (busy_a !== 1'b0 || cmd_ready_a !== 1'b1) begin failures++; $display("FAIL b2b_idle cmd=%0d busy=%b ready=%b exp 0 1", n + 1, busy_a, cmd_ready_a); end
        if (n == 299) cmd_valid_a = 1'b0;
      end
    end
    checks++; if (seq_a !== 8'd44) begin failures++; $display("FAIL b2b_seq_end got=%0d exp=44", seq_a); end
    $display("test_back_to_back done");
  endtask

  task automatic test_reset_mid;
    logic [83:0] er;
    er = pk(3'b101, 9'd0, 9'd0, 9'd0, 8'h00, 8'd44, 4'b1110, 32'hAA);
    cmd_valid_a = 1'b1; cmd_opcode_a = 4'b1110; cmd_payload_a = 32'hAA;
    tick;
    cmd_valid_a = 1'b0;
    checks++; if (red_a !== er) begin failures++; $display("FAIL rmid_emit got=%h exp=%h", red_a, er); end
    rst = 1'b1;
    #1;
    checks++; if ({red_a, xpos_a, ypos_a} !== '0) begin failures++; $display("FAIL rmid_zero got nonzero exp=0"); end
    checks++; if (seq_a !== 8'd0 || busy_a !== 1'b0 || cmd_ready_a !== 1'b0) begin failures++; $display("FAIL rmid_state seq=%0d busy=%b ready=%b exp 0 0 0", seq_a, busy_a, cmd_ready_a); end
    tick;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      checks++; if ({red_a, xpos_a, ypos_a} !== '0 || busy_a !== 1'b0) begin failures++; $display("FAIL rmid_replay cyc=%0d busy=%b exp no emission", i, busy_a); end
    end
    $display("test_reset_mid done");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_no_comm();
    test_allreduce();
    test_reduce();
    test_bad_opcode();
    test_comm_hold();
    test_neg_ports();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
